control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the lab CPU. It steps the T0..T7 fetch/execute sequence and decodes IR[31:27].
//  It drives the datapath strobes (PCout, MARin, Zlowin, Gra/Grb/Grc, ...) that the instruction benches
//  currently hand-drive. It sits directly upstream of the datapath; its outputs connect 1:1 to the datapath enables.
// PARAMETERS
//  MEM_WAIT   1  cycles Read/MDRin are held in memory-read states (T1, ld T6); valid range >=1
//  ALU_ADD    2  CONTROL code for add (also used for address/immediate calculation)
//  ALU_SUB    3  CONTROL code for sub
//  ALU_AND    4  CONTROL code for and
//  ALU_OR     5  CONTROL code for or
// PORTS
//  clock      in   1   system clock, rising edge
//  Clear      in   1   synchronous, active-low reset
//  IR         in   32  instruction register contents; opcode = IR[31:27]
//  Stop       in   1   halt request, sampled in T0
//  Run        out  1   1 while sequencing, 0 in RESET/HALT
//  PCout,Zlowout,MDRout,Rout,BAout,Cout  out 1 each  bus drivers
//  PCin,MARin,MDRin,IRin,Yin,Zlowin,Rin  out 1 each  register loads
//  IncPC,Read,Write,Gra,Grb,Grc          out 1 each  misc strobes
//  CONTROL    out  5   ALU op select
//  state_dbg  out  4   current state code (RESET=0,T0..T7=1..8,HALT=9)
// BEHAVIOUR
//  - Moore FSM: all outputs decode from the state register (plus IR in T3..T7).
//    Each strobe is high for the whole state cycle.
//  - Clear=0 at a clock edge -> state RESET, wait counter 0. In RESET all outputs are 0 and CONTROL=0.
//    RESET always advances to T0 on the next edge with Clear=1. Clear aborts any instruction mid-flight.
//  - T0: PCout MARin IncPC Zlowin. If Stop=1 go to HALT, else go to T1.
//  - T1: Zlowout PCin Read MDRin, held MEM_WAIT cycles by the wait counter, then T2.
//    A repeated PCin during the wait is benign because Z is unchanged.
//  - T2: MDRout IRin, then T3.
//  - Opcode sequences (T3 onward; last listed state returns to T0):
//    ld   00000  T3 Grb BAout Yin | T4 Cout CONTROL=ALU_ADD Zlowin | T5 Zlowout MARin
//                | T6 Read MDRin (MEM_WAIT cycles) | T7 MDRout Gra Rin
//    ldi  00001  T3,T4 as ld | T5 Zlowout Gra Rin
//    st   00010  T3..T5 as ld | T6 Gra Rout MDRin (Read=0) | T7 Write
//    add/sub/and/or  00011/00100/00101/00110
//                T3 Grb Rout Yin | T4 Grc Rout CONTROL=op Zlowin | T5 Zlowout Gra Rin
//    addi 01100  T3 Grb Rout Yin | T4 Cout CONTROL=ALU_ADD Zlowin | T5 Zlowout Gra Rin
//    halt 11011  T3 -> HALT
//    all other opcodes: nop, T3 with no strobes -> T0
//  - HALT: all strobes 0, Run=0. Only Clear=0 leaves HALT.
//  - CONTROL is 0 in every state except T4. IR is assumed stable from end of T2 until next T2.
//  - Wait counter: clears on entry to every state, increments each cycle in a memory-read state.
//    Advance when counter==MEM_WAIT-1.
//  - Simultaneous Clear=0 and Stop=1: Clear wins.
//  - Never two bus drivers active in one state (one-hot among *out signals).
// CONFIGURATION
//  CTRL_SINGLE_STEP_EN defined: adds input Step (1 bit).
//    The FSM holds in T0 with all strobes 0 until Step=1; T0 strobes then assert for exactly one cycle.
//    Stop is still honoured while waiting.
//  Not defined: no Step port; T0 lasts exactly one cycle.
// TESTING
//  1. Clear=0 for 2 cycles -> every output 0, state_dbg=0, Run=0. Release -> T0 next edge.
//  2. IR=32'h00800085 (ld), MEM_WAIT=1 -> 8 cycles T0..T7.
//     T4 CONTROL=2 Cout Zlowin; T6 Read MDRin; T7 MDRout Gra Rin; back to T0.
//  3. MEM_WAIT=3, ld -> T1 and T6 each last 3 cycles with Read=1. Total 12 cycles/instruction.
//  4. IR opcode 00100 (sub) -> T4 Grc Rout CONTROL=3 Zlowin. Return to T0 after T5 (6 cycles).
//     st -> T7 Write=1, Read=0 in T6.
//  5. Stop=1 during T0 -> HALT next edge, Run=0, holds 20 cycles.
//     Opcode 11011 -> HALT after T3. Clear=0 during T6 of ld -> RESET, no Rin pulse.
//  6. CTRL_SINGLE_STEP_EN: Step=0 -> stays T0 with strobes low. Step pulse -> one complete instruction, then waits again.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T0..T7 fetch/execute control unit for the lab CPU
// Ports: clock, Clear (sync active-low reset), IR (opcode IR[31:27]), Stop (halt request sampled in T0),
//   Run (1 while sequencing), bus drivers PCout/Zlowout/MDRout/Rout/BAout/Cout,
//   register loads PCin/MARin/MDRin/IRin/Yin/Zlowin/Rin, strobes IncPC/Read/Write/Gra/Grb/Grc,
//   CONTROL (ALU op), state_dbg (RESET=0, T0..T7=1..8, HALT=9).
// Macro CTRL_SINGLE_STEP_EN adds input Step: T0 idles with strobes low until Step=1.
module control_sequencer #(
  parameter int         MEM_WAIT = 1,
  parameter logic [4:0] ALU_ADD  = 5'd2,
  parameter logic [4:0] ALU_SUB  = 5'd3,
  parameter logic [4:0] ALU_AND  = 5'd4,
  parameter logic [4:0] ALU_OR   = 5'd5
) (
  input  logic        clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Stop,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic        Run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Rin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  CONTROL,
  output logic [3:0]  state_dbg
);
  typedef enum logic [3:0] {RESET = 4'd0, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  localparam int CW = MEM_WAIT > 1 ? $clog2(MEM_WAIT) : 1;
  localparam logic [18:0] PCO = 19'd1 << 18, ZO = 19'd1 << 17, MDRO = 19'd1 << 16, RO = 19'd1 << 15;
  localparam logic [18:0] BAO = 19'd1 << 14, CO = 19'd1 << 13, PCI = 19'd1 << 12, MARI = 19'd1 << 11;
  localparam logic [18:0] MDRI = 19'd1 << 10, IRI = 19'd1 << 9, YI = 19'd1 << 8, ZI = 19'd1 << 7;
  localparam logic [18:0] RI = 19'd1 << 6, INC = 19'd1 << 5, RD = 19'd1 << 4, WR = 19'd1 << 3;
  localparam logic [18:0] GRA = 19'd1 << 2, GRB = 19'd1 << 1, GRC = 19'd1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [18:0] strb;
  logic [4:0] op;
  logic is_ld, is_ldi, is_st, is_alu, is_addi, is_halt, last, mem_rd, t0_on;
  logic unused_ir;
  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_ld     = op == 5'b00000;
  assign is_ldi    = op == 5'b00001;
  assign is_st     = op == 5'b00010;
  assign is_alu    = op >= 5'b00011 && op <= 5'b00110;
  assign is_addi   = op == 5'b01100;
  assign is_halt   = op == 5'b11011;
  assign last      = cnt_q == CW'(MEM_WAIT - 1);
  assign mem_rd    = state_q == T1 || (state_q == T6 && is_ld);
`ifdef CTRL_SINGLE_STEP_EN
  // armed_q marks the one T0 cycle that follows a Step request
  logic armed_q, armed_d;
  assign t0_on = armed_q;
`else
  assign t0_on = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
`ifdef CTRL_SINGLE_STEP_EN
    armed_d = 1'b0;
`endif
    case (state_q)
      RESET: state_d = T0;
`ifdef CTRL_SINGLE_STEP_EN
      T0: begin
        state_d = Stop ? HALT : armed_q ? T1 : T0;
        armed_d = !Stop && !armed_q && Step;
      end
`else
      T0: state_d = Stop ? HALT : T1;
`endif
      T1: state_d = last ? T2 : T1;
      T2: state_d = T3;
      T3: state_d = is_halt ? HALT : (is_ld || is_ldi || is_st || is_alu || is_addi) ? T4 : T0;
      T4: state_d = T5;
      T5: state_d = (is_ld || is_st) ? T6 : T0;
      T6: state_d = (is_st || last) ? T7 : T6;
      T7: state_d = T0;
      default: state_d = state_q;
    endcase
    cnt_d = (mem_rd && state_d == state_q) ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clock) begin
    if (!Clear) begin
      state_q <= RESET;
      cnt_q   <= '0;
`ifdef CTRL_SINGLE_STEP_EN
      armed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef CTRL_SINGLE_STEP_EN
      armed_q <= armed_d;
`endif
    end
  end
  always_comb begin
    strb = '0;
    case (state_q)
      T0: strb = t0_on ? (PCO | MARI | INC | ZI) : '0;
      T1: strb = ZO | PCI | RD | MDRI;
      T2: strb = MDRO | IRI;
      T3: strb = (is_ld || is_ldi || is_st) ? (GRB | BAO | YI) : (is_alu || is_addi) ? (GRB | RO | YI) : '0;
      T4: strb = is_alu ? (GRC | RO | ZI) : (CO | ZI);
      T5: strb = (is_ld || is_st) ? (ZO | MARI) : (ZO | GRA | RI);
      T6: strb = is_st ? (GRA | RO | MDRI) : (RD | MDRI);
      T7: strb = is_st ? WR : (MDRO | GRA | RI);
      default: strb = '0;
    endcase
  end
  assign {PCout, Zlowout, MDRout, Rout, BAout, Cout, PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin,
          IncPC, Read, Write, Gra, Grb, Grc} = strb;
  assign CONTROL   = state_q != T4 ? 5'd0 : !is_alu ? ALU_ADD : op == 5'b00011 ? ALU_ADD :
                     op == 5'b00100 ? ALU_SUB : op == 5'b00101 ? ALU_AND : ALU_OR;
  assign Run       = state_q != RESET && state_q != HALT;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of the control_sequencer state walk and strobes
module tb_control_sequencer;
  localparam logic [18:0] PCO = 19'd1 << 18, ZO = 19'd1 << 17, MDRO = 19'd1 << 16, RO = 19'd1 << 15;
  localparam logic [18:0] BAO = 19'd1 << 14, CO = 19'd1 << 13, PCI = 19'd1 << 12, MARI = 19'd1 << 11;
  localparam logic [18:0] MDRI = 19'd1 << 10, IRI = 19'd1 << 9, YI = 19'd1 << 8, ZI = 19'd1 << 7;
  localparam logic [18:0] RI = 19'd1 << 6, INC = 19'd1 << 5, RD = 19'd1 << 4, WR = 19'd1 << 3;
  localparam logic [18:0] GRA = 19'd1 << 2, GRB = 19'd1 << 1, GRC = 19'd1;
  localparam logic [18:0] T0S = PCO | MARI | INC | ZI;
  localparam logic [31:0] IR_LD = 32'h00800085, IR_SUB = {5'b00100, 27'h0}, IR_ST = {5'b00010, 27'h0};
  localparam logic [31:0] IR_ADDI = {5'b01100, 27'h0}, IR_NOP = {5'b01111, 27'h0}, IR_HALT = {5'b11011, 27'h0};
  logic clock = 1'b0, Clear = 1'b0, Stop = 1'b0;
  logic [31:0] IR = 32'h0;
`ifdef CTRL_SINGLE_STEP_EN
  logic Step = 1'b0;
`endif
  logic [1:0][28:0] obs;
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic Run, PCout, Zlowout, MDRout, Rout, BAout, Cout, PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin;
    logic IncPC, Read, Write, Gra, Grb, Grc;
    logic [4:0] CONTROL;
    logic [3:0] state_dbg;
    control_sequencer #(.MEM_WAIT(g == 0 ? 1 : 3)) dut (
      .clock(clock), .Clear(Clear), .IR(IR), .Stop(Stop),
`ifdef CTRL_SINGLE_STEP_EN
      .Step(Step),
`endif
      .Run(Run), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout), .BAout(BAout),
      .Cout(Cout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .Zlowin(Zlowin), .Rin(Rin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
      .Grb(Grb), .Grc(Grc), .CONTROL(CONTROL), .state_dbg(state_dbg)
    );
    assign obs[g] = {state_dbg, Run, CONTROL, PCout, Zlowout, MDRout, Rout, BAout, Cout, PCin, MARin,
                     MDRin, IRin, Yin, Zlowin, Rin, IncPC, Read, Write, Gra, Grb, Grc};
  end
  function automatic logic [28:0] e(input logic [3:0] s, input logic [4:0] c, input logic [18:0] st);
    return {s, s != 4'd0 && s != 4'd9, c, st};
  endfunction
  task automatic check(input string tag, input logic [28:0] got, input logic [28:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic adv(input int g, input string tag, input logic [28:0] exp);
    tick();
    check(tag, obs[g], exp);
  endtask
  task automatic do_reset();
    Clear = 1'b0;
    tick();
    check("rst", obs[0], 29'h0);
    Clear = 1'b1;
  endtask
  task automatic t0(input int g, input string tag);
`ifdef CTRL_SINGLE_STEP_EN
    adv(g, {tag, "_idle"}, e(1, 0, 19'h0));
    Step = 1'b1;
    adv(g, tag, e(1, 0, T0S));
    Step = 1'b0;
`else
    adv(g, tag, e(1, 0, T0S));
`endif
  endtask
  task automatic fetch(input string tag);
    adv(0, {tag, "_t1"}, e(2, 0, ZO | PCI | RD | MDRI));
    adv(0, {tag, "_t2"}, e(3, 0, MDRO | IRI));
  endtask
  initial begin
    IR = IR_LD;
    tick();
    tick();
    check("rst_a", obs[0], 29'h0);
    check("rst_b", obs[1], 29'h0);
    Clear = 1'b1;
    t0(0, "ld_t0");
    fetch("ld");
    adv(0, "ld_t3", e(4, 0, GRB | BAO | YI));
    adv(0, "ld_t4", e(5, 2, CO | ZI));
    adv(0, "ld_t5", e(6, 0, ZO | MARI));
    adv(0, "ld_t6", e(7, 0, RD | MDRI));
    adv(0, "ld_t7", e(8, 0, MDRO | GRA | RI));
    t0(0, "ld_ret");
    do_reset();
    t0(1, "mw3_t0");
    for (int i = 0; i < 3; i++) adv(1, "mw3_t1", e(2, 0, ZO | PCI | RD | MDRI));
    adv(1, "mw3_t2", e(3, 0, MDRO | IRI));
    adv(1, "mw3_t3", e(4, 0, GRB | BAO | YI));
    adv(1, "mw3_t4", e(5, 2, CO | ZI));
    adv(1, "mw3_t5", e(6, 0, ZO | MARI));
    for (int i = 0; i < 3; i++) adv(1, "mw3_t6", e(7, 0, RD | MDRI));
    adv(1, "mw3_t7", e(8, 0, MDRO | GRA | RI));
    t0(1, "mw3_ret");
    do_reset();
    IR = IR_SUB;
    t0(0, "sub_t0");
    fetch("sub");
    adv(0, "sub_t3", e(4, 0, GRB | RO | YI));
    adv(0, "sub_t4", e(5, 3, GRC | RO | ZI));
    adv(0, "sub_t5", e(6, 0, ZO | GRA | RI));
    t0(0, "sub_ret");
    IR = IR_ST;
    fetch("st");
    adv(0, "st_t3", e(4, 0, GRB | BAO | YI));
    adv(0, "st_t4", e(5, 2, CO | ZI));
    adv(0, "st_t5", e(6, 0, ZO | MARI));
    adv(0, "st_t6", e(7, 0, GRA | RO | MDRI));
    adv(0, "st_t7", e(8, 0, WR));
    t0(0, "st_ret");
    IR = IR_ADDI;
    fetch("addi");
    adv(0, "addi_t3", e(4, 0, GRB | RO | YI));
    adv(0, "addi_t4", e(5, 2, CO | ZI));
    adv(0, "addi_t5", e(6, 0, ZO | GRA | RI));
    t0(0, "addi_ret");
    IR = IR_NOP;
    fetch("nop");
    adv(0, "nop_t3", e(4, 0, 19'h0));
    t0(0, "nop_ret");
    IR = IR_HALT;
    fetch("hlt");
    adv(0, "hlt_t3", e(4, 0, 19'h0));
    adv(0, "hlt_halt", e(9, 0, 19'h0));
    adv(0, "hlt_hold", e(9, 0, 19'h0));
    do_reset();
    IR = IR_LD;
    t0(0, "stop_t0");
    Stop = 1'b1;
    adv(0, "stop_halt", e(9, 0, 19'h0));
    Stop = 1'b0;
    for (int i = 0; i < 20; i++) adv(0, "stop_hold", e(9, 0, 19'h0));
    Stop = 1'b1;
    Clear = 1'b0;
    adv(0, "halt_clear", e(0, 0, 19'h0));
    Clear = 1'b1;
    Stop = 1'b0;
    t0(0, "cs_t0");
    Stop = 1'b1;
    Clear = 1'b0;
    adv(0, "clear_wins", e(0, 0, 19'h0));
    Clear = 1'b1;
    Stop = 1'b0;
    t0(0, "abort_t0");
    fetch("abort");
    adv(0, "abort_t3", e(4, 0, GRB | BAO | YI));
    adv(0, "abort_t4", e(5, 2, CO | ZI));
    adv(0, "abort_t5", e(6, 0, ZO | MARI));
    adv(0, "abort_t6", e(7, 0, RD | MDRI));
    Clear = 1'b0;
    adv(0, "abort_rst", e(0, 0, 19'h0));
    Clear = 1'b1;
    t0(0, "abort_ret");
`ifdef CTRL_SINGLE_STEP_EN
    do_reset();
    IR = IR_NOP;
    for (int i = 0; i < 5; i++) adv(0, "ss_idle", e(1, 0, 19'h0));
    Step = 1'b1;
    adv(0, "ss_arm", e(1, 0, T0S));
    Step = 1'b0;
    fetch("ss");
    adv(0, "ss_t3", e(4, 0, 19'h0));
    adv(0, "ss_back", e(1, 0, 19'h0));
    adv(0, "ss_wait", e(1, 0, 19'h0));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
